pc_fetch_unit: RTL and testbench

Program-counter and fetch-control stage for the single-cycle MIPS core. It sits directly upstream of the instruction memory: it holds the PC, drives the memory's 8-bit word address, and returns the fetched word to decode. It selects the next PC from sequential, branch, jump and jump-register sources. It also tracks stall and halt state, raises address faults, and counts retired instructions.

---
 rtl/mips_pkg.sv | 21 ++
 rtl/next_pc_sel.sv | 43 ++++
 rtl/pc_fetch_unit.sv | 131 +++++++++++++
 tb/tb_pc_fetch_unit.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared constants for the single-cycle MIPS core: IMEM geometry, fetch FSM
// states and the control-flow opcodes.
package mips_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam int unsigned IMEM_DEPTH = 256;
  localparam int unsigned IMEM_AW    = 8;

  typedef enum logic [1:0] {
    FS_RUN   = 2'd0,
    FS_STALL = 2'd1,
    FS_HALT  = 2'd2
  } fetch_state_e;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] FUNCT_JR   = 6'h08;

endpackage

// File: rtl/next_pc_sel.sv
// Next-PC target computation, jr > j > branch > sequential priority select,
// and the out-of-IMEM / misaligned-jr fault check.
module next_pc_sel
  import mips_pkg::*;
(
  input  logic [31:0] pc_plus4_i,
  input  logic        branch_taken_i,
  input  logic [15:0] branch_imm_i,
  input  logic        jump_i,
  input  logic [25:0] jump_index_i,
  input  logic        jump_reg_i,
  input  logic [31:0] jr_target_i,
  output logic [31:0] next_pc_c_o,
  output logic        addr_fault_c_o
);

  localparam int unsigned PC_W    = 32;
  localparam int unsigned BYTE_AW = IMEM_AW + 2;

  logic [PC_W-1:0] br_off;
  logic [PC_W-1:0] br_tgt;
  logic [PC_W-1:0] j_tgt;

  always_comb begin
    br_off = {{14{branch_imm_i[15]}}, branch_imm_i, 2'b00};
    br_tgt = pc_plus4_i + br_off;
    j_tgt  = {pc_plus4_i[31:28], jump_index_i, 2'b00};

    next_pc_c_o = pc_plus4_i;
    if (jump_reg_i) begin
      next_pc_c_o = jr_target_i;
    end else if (jump_i) begin
      next_pc_c_o = j_tgt;
    end else if (branch_taken_i) begin
      next_pc_c_o = br_tgt;
    end

    // Anything above the 256-word window, or a jr to a non-word address.
    addr_fault_c_o = (next_pc_c_o[PC_W-1:BYTE_AW] != '0) ||
                     (jump_reg_i && (jr_target_i[1:0] != 2'b00));
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register, RUN/STALL/HALT fetch FSM, sticky address fault and retire count.
// Optional FETCH_HALT_ON_ZERO_EN: halt after ZERO_RUN consecutive retired zero words.
module pc_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned ZERO_RUN = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_imm,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        jump_reg,
  input  logic [31:0] jr_target,
  input  logic [31:0] imem_rd,
  output logic [7:0]  imem_addr,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        halted,
  output logic        fault,
  output logic [31:0] retired
);

  localparam int unsigned     PC_W        = 32;
  localparam logic [PC_W-1:0] RETIRED_MAX = '1;

  if (RESET_PC[1:0] != 2'b00 || ZERO_RUN == 0) begin : g_param_check
    $error("pc_fetch_unit: RESET_PC must be word-aligned and ZERO_RUN nonzero");
  end

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] retired_q, retired_d;
  logic            fault_q, fault_d;
  logic            halted_q;
  logic [PC_W-1:0] next_pc_c;
  logic            addr_fault_c;

  assign pc        = pc_q;
  assign pc_plus4  = pc_q + 32'd4;
  assign imem_addr = pc_q[IMEM_AW+1:2];
  assign instr     = halted_q ? '0 : imem_rd;
  assign halted    = halted_q;
  assign fault     = fault_q;
  assign retired   = retired_q;

  next_pc_sel u_next_pc_sel (
    .pc_plus4_i     (pc_plus4),
    .branch_taken_i (branch_taken),
    .branch_imm_i   (branch_imm),
    .jump_i         (jump),
    .jump_index_i   (jump_index),
    .jump_reg_i     (jump_reg),
    .jr_target_i    (jr_target),
    .next_pc_c_o    (next_pc_c),
    .addr_fault_c_o (addr_fault_c)
  );

`ifdef FETCH_HALT_ON_ZERO_EN
  logic [PC_W-1:0] zcnt_q, zcnt_d;
`endif

  // Next-state: stall holds everything; a fault freezes the PC and halts.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    retired_d = retired_q;
    fault_d   = fault_q;
`ifdef FETCH_HALT_ON_ZERO_EN
    zcnt_d    = zcnt_q;
`endif
    case (state_q)
      FS_RUN, FS_STALL: begin
        if (stall) begin
          state_d = FS_STALL;
        end else if (addr_fault_c) begin
          fault_d = 1'b1;
          state_d = FS_HALT;
        end else begin
          state_d = FS_RUN;
          pc_d    = next_pc_c;
          if (retired_q != RETIRED_MAX) begin
            retired_d = retired_q + 32'd1;
          end
`ifdef FETCH_HALT_ON_ZERO_EN
          if (instr == '0) begin
            zcnt_d = zcnt_q + 32'd1;
            if (zcnt_d >= 32'(ZERO_RUN)) begin
              state_d = FS_HALT;
            end
          end else begin
            zcnt_d = '0;
          end
`endif
        end
      end
      default: state_d = FS_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FS_RUN;
      pc_q      <= RESET_PC;
      retired_q <= '0;
      fault_q   <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      retired_q <= retired_d;
      fault_q   <= fault_d;
      halted_q  <= (state_d == FS_HALT);
    end
  end

`ifdef FETCH_HALT_ON_ZERO_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zcnt_q <= '0;
    end else begin
      zcnt_q <= zcnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed vector table, corner sequences and random
// control traffic checked against a behavioural fetch model.
module tb_pc_fetch_unit;
  import mips_pkg::*;

  localparam int unsigned ZR = 4;

  logic        clk, rst_n, stall, branch_taken, jump, jump_reg;
  logic [15:0] branch_imm;
  logic [25:0] jump_index;
  logic [31:0] jr_target, imem_rd, instr, pc, pc_plus4, retired;
  logic [7:0]  imem_addr;
  logic        halted, fault;

  logic [31:0] mem [IMEM_DEPTH];

  int vectors;
  int miscompares;

  logic [31:0] m_pc, m_ret;
  logic        m_fault, m_halt;
`ifdef FETCH_HALT_ON_ZERO_EN
  int unsigned m_zrun;
`endif

  typedef struct packed {
    logic        stall;
    logic        br;
    logic [15:0] imm;
    logic        j;
    logic [25:0] idx;
    logic        jr;
    logic [31:0] jrt;
  } in_t;

  typedef struct {
    in_t         in;
    logic [31:0] pc;
    logic [31:0] ret;
  } row_t;

  pc_fetch_unit #(.RESET_PC(32'h0), .ZERO_RUN(ZR)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_imm   (branch_imm),
    .jump         (jump),
    .jump_index   (jump_index),
    .jump_reg     (jump_reg),
    .jr_target    (jr_target),
    .imem_rd      (imem_rd),
    .imem_addr    (imem_addr),
    .instr        (instr),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .halted       (halted),
    .fault        (fault),
    .retired      (retired)
  );

  assign imem_rd = mem[imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic in_t mk(logic s, logic b, logic [15:0] imm, logic j,
                             logic [25:0] idx, logic r, logic [31:0] t);
    in_t v;
    v.stall = s; v.br = b; v.imm = imm; v.j = j; v.idx = idx; v.jr = r; v.jrt = t;
    return v;
  endfunction

  function automatic in_t rand_in();
    in_t v;
    v.stall = ($urandom_range(0, 4) == 0);
    v.br    = ($urandom_range(0, 3) == 0);
    v.imm   = ($urandom_range(0, 7) == 0) ? 16'($urandom)
                                          : 16'($urandom_range(0, 63)) - 16'd32;
    v.j     = ($urandom_range(0, 9) == 0);
    v.idx   = ($urandom_range(0, 7) == 0) ? 26'($urandom) : 26'($urandom_range(0, 255));
    v.jr    = ($urandom_range(0, 19) == 0);
    v.jrt   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 1100))
                                          : 32'($urandom_range(0, 255)) * 4;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference fetch model: plain address arithmetic on byte addresses.
  task automatic model_reset();
    m_pc = 32'h0; m_ret = 32'h0; m_fault = 1'b0; m_halt = 1'b0;
`ifdef FETCH_HALT_ON_ZERO_EN
    m_zrun = 0;
`endif
  endtask

  task automatic model_step(input in_t v);
    logic [31:0] tgt;
    logic [31:0] word;
    logic        bad;
    if (m_halt || v.stall) return;
    if (v.jr)      tgt = v.jrt;
    else if (v.j)  tgt = ((m_pc + 32'd4) & 32'hF000_0000) | (32'(v.idx) * 32'd4);
    else if (v.br) tgt = m_pc + 32'd4 + 32'(int'($signed(v.imm)) * 4);
    else           tgt = m_pc + 32'd4;
    bad = (tgt >= 32'd1024) || (v.jr && (v.jrt % 4 != 0));
    if (bad) begin
      m_fault = 1'b1;
      m_halt  = 1'b1;
    end else begin
      word = mem[8'(m_pc / 4)];
      m_pc = tgt;
      if (m_ret != 32'hFFFF_FFFF) m_ret = m_ret + 32'd1;
`ifdef FETCH_HALT_ON_ZERO_EN
      if (word == 32'h0) begin
        m_zrun++;
        if (m_zrun >= ZR) m_halt = 1'b1;
      end else begin
        m_zrun = 0;
      end
`else
      if (word == 32'h0) m_ret = m_ret;
`endif
    end
  endtask

  task automatic check_outputs();
    check("pc", pc, m_pc);
    check("imem_addr", 32'(imem_addr), m_pc / 4);
    check("pc_plus4", pc_plus4, m_pc + 32'd4);
    check("instr", instr, m_halt ? 32'h0 : mem[8'(m_pc / 4)]);
    check("halted", 32'(halted), 32'(m_halt));
    check("fault", 32'(fault), 32'(m_fault));
    check("retired", retired, m_ret);
  endtask

  task automatic drive_idle();
    stall = 1'b0; branch_taken = 1'b0; branch_imm = '0; jump = 1'b0;
    jump_index = '0; jump_reg = 1'b0; jr_target = '0;
  endtask

  task automatic apply(input in_t v);
    stall = v.stall; branch_taken = v.br; branch_imm = v.imm; jump = v.j;
    jump_index = v.idx; jump_reg = v.jr; jr_target = v.jrt;
    @(posedge clk);
    model_step(v);
    #1;
    check_outputs();
  endtask

  // Asynchronous reset dropped mid-cycle, held across an edge, released on negedge.
  task automatic do_reset();
    drive_idle();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  row_t tbl [15];
  in_t  seq_v;
  in_t  rv;

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b1;
    drive_idle();
    for (int i = 0; i < int'(IMEM_DEPTH); i++) begin
      if (i % 3 == 0)      mem[i] = {OP_J, 26'(i + 1)};
      else if (i % 3 == 1) mem[i] = {OP_BEQ, 5'(i), 5'd0, 16'(i)};
      else                 mem[i] = {OP_SPECIAL, 5'(i), 15'd0, FUNCT_JR};
    end
    for (int i = 14; i < 18; i++) mem[i] = 32'h0;

    seq_v   = mk(0, 0, 16'h0, 0, 26'd0, 0, 32'h0);
    tbl[0]  = '{seq_v, 32'h04, 32'd1};
    tbl[1]  = '{seq_v, 32'h08, 32'd2};
    tbl[2]  = '{seq_v, 32'h0C, 32'd3};
    tbl[3]  = '{seq_v, 32'h10, 32'd4};
    tbl[4]  = '{seq_v, 32'h14, 32'd5};
    tbl[5]  = '{mk(0, 1, 16'h0006, 0, 26'd0, 0, 32'h0), 32'h30, 32'd6};
    tbl[6]  = '{mk(0, 1, 16'hFFFE, 0, 26'd0, 0, 32'h0), 32'h2C, 32'd7};
    tbl[7]  = '{mk(0, 0, 16'h0, 1, 26'd9, 0, 32'h0), 32'h24, 32'd8};
    tbl[8]  = '{mk(0, 0, 16'h0, 1, 26'd5, 0, 32'h0), 32'h14, 32'd9};
    tbl[9]  = '{mk(0, 1, 16'h0006, 1, 26'd2, 0, 32'h0), 32'h08, 32'd10};
    tbl[10] = '{mk(1, 0, 16'h0, 1, 26'd100, 0, 32'h0), 32'h08, 32'd10};
    tbl[11] = '{mk(1, 0, 16'h0, 0, 26'd0, 1, 32'h3), 32'h08, 32'd10};
    tbl[12] = '{mk(1, 1, 16'h0010, 0, 26'd0, 0, 32'h0), 32'h08, 32'd10};
    tbl[13] = '{seq_v, 32'h0C, 32'd11};
    tbl[14] = '{mk(0, 1, 16'h0006, 1, 26'd3, 1, 32'h40), 32'h40, 32'd12};

    #1;
    do_reset();
    check("reset_pc", pc, 32'h0);
    check("reset_retired", retired, 32'h0);

    for (int i = 0; i < 15; i++) begin
      apply(tbl[i].in);
      check($sformatf("tbl%0d_pc", i), pc, tbl[i].pc);
      check($sformatf("tbl%0d_retired", i), retired, tbl[i].ret);
      check($sformatf("tbl%0d_halted", i), 32'(halted), 32'h0);
    end

    // jr outside the window: sticky fault, frozen PC, NOP output.
    apply(mk(0, 0, 16'h0, 0, 26'd0, 1, 32'h402));
    check("jrfault_pc", pc, 32'h40);
    check("jrfault_fault", 32'(fault), 32'h1);
    check("jrfault_halted", 32'(halted), 32'h1);
    check("jrfault_instr", instr, 32'h0);
    check("jrfault_retired", retired, 32'd12);
    apply(mk(0, 1, 16'h0006, 1, 26'd3, 1, 32'h8));
    apply(seq_v);
    check("halt_absorb_pc", pc, 32'h40);
    do_reset();
    check("rst_after_halt_fault", 32'(fault), 32'h0);
    check("rst_after_halt_pc", pc, 32'h0);

    // Sequential step off the last word faults.
    apply(mk(0, 0, 16'h0, 0, 26'd0, 1, 32'h3FC));
    check("last_word_pc", pc, 32'h3FC);
    apply(seq_v);
    check("overrun_fault", 32'(fault), 32'h1);
    check("overrun_pc", pc, 32'h3FC);
    check("overrun_retired", retired, 32'd1);
    do_reset();

    // Misaligned jr target inside the window.
    apply(mk(0, 0, 16'h0, 0, 26'd0, 1, 32'h41));
    check("jr_misalign_fault", 32'(fault), 32'h1);
    check("jr_misalign_pc", pc, 32'h0);
    do_reset();

    // Backward branch below address 0 wraps to the top of the space.
    apply(mk(0, 1, 16'hFFFE, 0, 26'd0, 0, 32'h0));
    check("br_wrap_fault", 32'(fault), 32'h1);
    do_reset();

    // Run of zero words at words 14..17.
    apply(mk(0, 0, 16'h0, 1, 26'd14, 0, 32'h0));
    check("zrun_start_pc", pc, 32'h38);
    for (int i = 0; i < 3; i++) apply(seq_v);
    check("zrun_3_halted", 32'(halted), 32'h0);
    apply(seq_v);
    check("zrun_4_pc", pc, 32'h48);
    check("zrun_4_fault", 32'(fault), 32'h0);
    check("zrun_4_retired", retired, 32'd5);
`ifdef FETCH_HALT_ON_ZERO_EN
    check("zrun_4_halted", 32'(halted), 32'h1);
`else
    check("zrun_4_halted", 32'(halted), 32'h0);
`endif

    // Random control traffic.
    for (int ep = 0; ep < 12; ep++) begin
      do_reset();
      for (int c = 0; c < 50; c++) begin
        if (c == 25 && ep % 3 == 0) do_reset();
        rv = rand_in();
        apply(rv);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
